bcd_to_bin_converter: RTL
=========================

Name: bcd_to_bin_converter

Overview:
- Iterative multi-digit BCD-to-binary converter; the inverse of the team's binary-to-BCD path.
- Accepts a packed BCD word over a valid/ready handshake.
- Processes one digit per clock, most-significant first, using acc <= acc*10 + digit.
- Returns the binary value over a valid/ready output handshake. Sits between BCD-keypad/display front-ends and binary datapath logic.

Parameters:
- DIGITS, 3, number of BCD digits in the input word (1..9).
- BIN_W, derived localparam (10 for DIGITS=3) = ceil(log2(10^DIGITS)); width of the binary result. Not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  bcd_in holds a word to convert.
- in_ready  output  1  block can accept a word; high only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; digit DIGITS-1 in the MS nibble.
- out_valid  output  1  bin_out and err_out are valid.
- out_ready  input  1  consumer accepts the result.
- bin_out  output  BIN_W  binary result.
- err_out  output  1  at least one input nibble was greater than 9 (see Optional Feature).

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, bin_out=0, err_out=0, internal accumulator/shift/count=0. Bench does not drive in_valid while rst is high.
- FSM states:
  - IDLE: in_ready=1. On in_valid at edge E0: capture bcd_in into shift register, acc=0, cnt=DIGITS-1, err=0; go to CONV.
  - CONV: in_ready=0. Each edge: acc <= (acc*10 + MS nibble) truncated to BIN_W; shift register <<= 4. At the edge where cnt==0, go to DONE and set out_valid=1; otherwise cnt decrements.
  - DONE: out_valid=1; bin_out and err_out held stable. On out_valid && out_ready: out_valid<=0, go to IDLE.
- Latency: acceptance at E0; CONV edges E1..E_DIGITS; out_valid is high after E_DIGITS, i.e. DIGITS cycles after acceptance.
- Throughput: one word per DIGITS+2 cycles with out_ready held high. No overlap: in_ready stays low until the cycle after the output handshake.
- Arithmetic: acc*10 is computed as (acc<<3)+(acc<<1) at BIN_W+4 bits, then truncated to BIN_W. Any legal input (value at most 10^DIGITS-1) is exact.
- bin_out is driven from acc only in DONE; it holds its last value in IDLE and CONV.
- Boundary conditions:
  - out_ready held low in DONE: hold indefinitely, outputs stable, in_valid ignored.
  - out_ready high on entry to DONE: one-cycle out_valid pulse.
  - in_valid low in IDLE: no state change.
  - in_valid changes while not in IDLE: ignored, because in_ready=0.
  - rst asserted mid-conversion: all state returns immediately to reset values and the partial result is discarded; no out_valid.
  - DIGITS=1: a single CONV cycle.

Optional Feature:
- Macro: BCD2BIN_ERR_CHECK_EN.
- Defined: during CONV, any nibble greater than 9 sets a sticky err flag.
  - In DONE: err_out=1 and bin_out forced to 0.
  - err is cleared on acceptance of the next word.
- Undefined: err_out tied to 0. Nibbles 10..15 are used arithmetically as their value, with the result modulo 2^BIN_W. No checker logic is synthesised.

Decomposition:
- Package bcd2bin_pkg:
  - State enum {IDLE, CONV, DONE}.
  - BCD_DIGIT_W=4 and BCD_MAX_DIGIT=9.
  - Function returning ceil(log2(10^n)), used to derive BIN_W.
- Sub-module bcd_mac10: combinational acc*10+digit with BIN_W truncation and, when enabled, the digit>9 compare. It is instantiated once.

Test Plan:
- Reset, then bcd_in=0x999, in_valid for 1 cycle, out_ready=1 -> out_valid 3 cycles after acceptance, bin_out=999, err_out=0, in_ready back to 1 the following cycle.
- bcd_in=0x000 -> bin_out=0. bcd_in=0x001 -> bin_out=1. bcd_in=0x100 -> bin_out=100.
- bcd_in=0x123, out_ready low for 5 cycles after out_valid -> bin_out=123 held stable and in_ready=0 throughout; handshake on cycle 6, then IDLE.
- bcd_in=0x1A3:
  - With BCD2BIN_ERR_CHECK_EN -> err_out=1, bin_out=0; next word 0x042 -> err_out=0, bin_out=42.
  - Without the macro -> err_out=0, bin_out=203.
- Accept 0x456, assert rst after the second CONV cycle -> out_valid never rises, all outputs 0, in_ready=1. Then 0x789 -> bin_out=789.
- Back-to-back stream 0x010, 0x500, 0x999 with in_valid held high and out_ready=1 -> results 10, 500, 999 in order, each DIGITS+2 cycles apart.

Source files
------------

// File: rtl/bcd_to_bin_converter_pkg.sv
// bcd2bin_pkg: shared states, BCD constants and result-width helper for bcd_to_bin_converter
package bcd2bin_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX_DIGIT = 9;
  function automatic int bin_width(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return $clog2(p);
  endfunction
endpackage

// File: rtl/bcd_to_bin_converter_mac10.sv
// bcd_mac10: acc*10 + digit truncated to BIN_W; digit>9 flag when BCD2BIN_ERR_CHECK_EN is defined
module bcd_mac10
  import bcd2bin_pkg::*;
#(
  parameter int BIN_W = 10
) (
  input  logic [BIN_W-1:0]       acc_i,
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BIN_W-1:0]       acc_o,
  output logic                   bad_o
);
  assign acc_o = (acc_i << 3) + (acc_i << 1) + BIN_W'(digit_i);
`ifdef BCD2BIN_ERR_CHECK_EN
  assign bad_o = digit_i > BCD_DIGIT_W'(BCD_MAX_DIGIT);
`else
  assign bad_o = 1'b0;
`endif
endmodule

// File: rtl/bcd_to_bin_converter.sv
// bcd_to_bin_converter: iterative MS-digit-first BCD to binary, one digit per clock; BCD2BIN_ERR_CHECK_EN enables nibble>9 error reporting
module bcd_to_bin_converter
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = 3,
  localparam int BIN_W = bin_width(DIGITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err_out
);
  localparam int SW = BCD_DIGIT_W * DIGITS;
  state_t            state_q, state_d;
  logic [SW-1:0]     shift_q, shift_d;
  logic [BIN_W-1:0]  acc_q, acc_d, bin_q, bin_d, mac_acc;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d, mac_bad;

  bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
    .acc_i  (acc_q),
    .digit_i(shift_q[SW-1 -: BCD_DIGIT_W]),
    .acc_o  (mac_acc),
    .bad_o  (mac_bad)
  );

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign bin_out   = bin_q;
  assign err_out   = err_q;

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // capture in IDLE, accumulate one digit per cycle in CONV, hold result in DONE until taken
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = CONV;
        shift_d = bcd_in;
        acc_d   = '0;
        cnt_d   = 4'(DIGITS - 1);
        err_d   = 1'b0;
      end
      CONV: begin
        acc_d   = mac_acc;
        shift_d = shift_q << BCD_DIGIT_W;
        err_d   = err_q | mac_bad;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          bin_d   = err_d ? '0 : mac_acc;
        end else cnt_d = cnt_q - 4'd1;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
endmodule
